delayed_branch_unit: RTL

DELAYED_BRANCH_UNIT -- requirements
Module: delayed_branch_unit

---
 rtl/kl_branch_pkg.sv | 42 ++++
 rtl/dbu_cond_eval.sv | 32 +++
 rtl/delayed_branch_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/kl_branch_pkg.sv
// Shared definitions for the delayed branch unit: condition codes, the HALT
// instruction head and the per-lane slot entry carried down the pipeline.
package kl_branch_pkg;

  // Condition codes carried with each delayed branch.
  localparam logic [2:0] CondNv = 3'd0;  // never
  localparam logic [2:0] CondAl = 3'd1;  // always
  localparam logic [2:0] CondEq = 3'd2;  // Z
  localparam logic [2:0] CondNe = 3'd3;  // !Z
  localparam logic [2:0] CondLt = 3'd4;  // N^V
  localparam logic [2:0] CondLe = 3'd5;  // (N^V)|Z
  localparam logic [2:0] CondGt = 3'd6;  // !(N^V)&!Z
  localparam logic [2:0] CondGe = 3'd7;  // !(N^V)

  // Instruction head that marks a HALT.
  localparam logic [7:0] HaltHead = 8'b001_00_111;

  // One lane's entry in a pipeline slot.
  typedef struct packed {
    logic        valid;
    logic [15:0] ir;
    logic [2:0]  cond;
  } slot_entry_t;

  // Build a slot entry from the S1 inputs; NV entries can never fire, so
  // they are dropped at capture instead of occupying the slot.
  function automatic slot_entry_t make_entry(input logic        b_valid,
                                             input logic [15:0] ir,
                                             input logic [2:0]  cond);
    slot_entry_t e;
    e.valid = b_valid && (cond != CondNv);
    e.ir    = ir;
    e.cond  = cond;
    return e;
  endfunction

  // True when the instruction head is HALT.
  function automatic logic is_halt(input logic [15:0] ir);
    return ir[15:8] == HaltHead;
  endfunction

endpackage

// File: rtl/dbu_cond_eval.sv
// Combinational flag test for a delayed-branch condition code.
module dbu_cond_eval
  import kl_branch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       N,
  input  logic       V,
  input  logic       Z,
  output logic       take
);

  logic w_lt;

  assign w_lt = N ^ V;

  // Decode the condition code against the current flags.
  always_comb begin
    take = 1'b0;
    unique case (cond)
      CondNv:  take = 1'b0;
      CondAl:  take = 1'b1;
      CondEq:  take = Z;
      CondNe:  take = !Z;
      CondLt:  take = w_lt;
      CondLe:  take = w_lt | Z;
      CondGt:  take = !w_lt & !Z;
      CondGe:  take = !w_lt;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/delayed_branch_unit.sv
// Delayed branch unit: captures per-lane delayed branches at S1, carries them
// DEPTH advance steps down a slot pipeline, evaluates the oldest slot against
// the flags every cycle and emits a registered one-cycle fire pulse with the
// stored instruction. A fire flushes every slot and blocks capture for one
// cycle. Optional fire statistics are enabled with DBU_STATS_EN.
module delayed_branch_unit
  import kl_branch_pkg::*;
#(
  parameter int unsigned DEPTH = 2  // legal 2..4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        p0_b_valid,
  input  logic        p1_b_valid,
  input  logic [15:0] p0_delayed_B_1in,
  input  logic [15:0] p1_delayed_B_1in,
  input  logic [2:0]  p0_delayed_cond_1in,
  input  logic [2:0]  p1_delayed_cond_1in,
  input  logic        N,
  input  logic        V,
  input  logic        Z,
  output logic        p0_do_delayed_B,
  output logic        p1_do_delayed_B,
  output logic [15:0] p0_IR_override,
  output logic [15:0] p1_IR_override,
  output logic        flush_younger,
  output logic        halt_pending
`ifdef DBU_STATS_EN
  ,
  output logic [15:0] fire_count
`endif
);

  localparam int unsigned Last = DEPTH - 1;

  if ((DEPTH < 2) || (DEPTH > 4)) begin : g_bad_depth
    $error("delayed_branch_unit: DEPTH must be in 2..4");
  end

  slot_entry_t r_p0_slot [DEPTH];
  slot_entry_t r_p1_slot [DEPTH];

  logic        r_p0_do;
  logic        r_p1_do;
  logic [15:0] r_p0_ir;
  logic [15:0] r_p1_ir;
  logic        r_flush;
  logic        r_halt;

  logic        w_p0_take;
  logic        w_p1_take;
  logic        w_p0_fire;
  logic        w_p1_fire;
  logic        w_fire;
  logic [15:0] w_fire_ir;
  logic        w_cap_en;
  slot_entry_t w_p0_cap;
  slot_entry_t w_p1_cap;

  dbu_cond_eval u_p0_eval (
    .cond (r_p0_slot[Last].cond),
    .N    (N),
    .V    (V),
    .Z    (Z),
    .take (w_p0_take)
  );

  dbu_cond_eval u_p1_eval (
    .cond (r_p1_slot[Last].cond),
    .N    (N),
    .V    (V),
    .Z    (Z),
    .take (w_p1_take)
  );

  // p0 is older in program order; when it fires, the p1 entry is discarded.
  assign w_p0_fire = r_p0_slot[Last].valid && w_p0_take;
  assign w_p1_fire = !w_p0_fire && r_p1_slot[Last].valid && w_p1_take;
  assign w_fire    = w_p0_fire || w_p1_fire;
  assign w_fire_ir = w_p0_fire ? r_p0_slot[Last].ir : r_p1_slot[Last].ir;

  // Capture is suppressed in the fire cycle: that S1 work is being flushed.
  assign w_cap_en = advance && !(r_p0_do || r_p1_do);
  assign w_p0_cap = make_entry(p0_b_valid && w_cap_en, p0_delayed_B_1in, p0_delayed_cond_1in);
  assign w_p1_cap = make_entry(p1_b_valid && w_cap_en, p1_delayed_B_1in, p1_delayed_cond_1in);

  // Slot pipeline: fire clears everything, otherwise shift on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_p0_slot[i] <= '0;
        r_p1_slot[i] <= '0;
      end
    end else if (w_fire) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_p0_slot[i].valid <= 1'b0;
        r_p1_slot[i].valid <= 1'b0;
      end
    end else if (advance) begin
      for (int unsigned i = Last; i > 0; i--) begin
        r_p0_slot[i] <= r_p0_slot[i-1];
        r_p1_slot[i] <= r_p1_slot[i-1];
      end
      r_p0_slot[0] <= w_p0_cap;
      r_p1_slot[0] <= w_p1_cap;
    end
  end

  // Registered fire pulse, override instruction and flush request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_do <= 1'b0;
      r_p1_do <= 1'b0;
      r_p0_ir <= '0;
      r_p1_ir <= '0;
      r_flush <= 1'b0;
    end else begin
      r_p0_do <= w_p0_fire;
      r_p1_do <= w_p1_fire;
      r_p0_ir <= w_p0_fire ? w_fire_ir : 16'h0000;
      r_p1_ir <= w_p1_fire ? w_fire_ir : 16'h0000;
      r_flush <= w_fire;
    end
  end

  // Sticky HALT indication, visible together with the fire pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halt <= 1'b0;
    end else if (w_fire && is_halt(w_fire_ir)) begin
      r_halt <= 1'b1;
    end
  end

  assign p0_do_delayed_B = r_p0_do;
  assign p1_do_delayed_B = r_p1_do;
  assign p0_IR_override  = r_p0_ir;
  assign p1_IR_override  = r_p1_ir;
  assign flush_younger   = r_flush;
  assign halt_pending    = r_halt;

`ifdef DBU_STATS_EN
  logic [15:0] r_fire_count;

  // Saturating fire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fire_count <= '0;
    end else if (w_fire && (r_fire_count != 16'hFFFF)) begin
      r_fire_count <= r_fire_count + 16'd1;
    end
  end

  assign fire_count = r_fire_count;
`endif

endmodule
